// File: rtl/reg_in_fifo.sv
// Input-side entry buffer: a small FIFO feeding pipeline stage x1 through a stall-aware output register.
// Optional same-edge bypass into the output register when the FIFO is empty: define REG_IN_FIFO_BYPASS_EN.
module reg_in_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              datainv,
  input  logic [DATA_W-1:0] datain,
  output logic              inputs_full,
  input  logic              pipe_stall,
  output logic              datavx1,
  output logic [DATA_W-1:0] datax1,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_nxt, rd_ptr_nxt;
  logic [IDX_W-1:0]  wr_idx, rd_idx;

  logic              fifo_empty, fifo_full;
  logic              push, pop, drop, bypass;

  logic              datavx1_nxt;
  logic [DATA_W-1:0] datax1_nxt;
  logic              overflow_nxt;

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];

  // The extra wrap bit separates "full" from "empty" when the index bits coincide.
  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_idx == rd_idx) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
  assign inputs_full = fifo_full;
  assign count       = CNT_W'(wr_ptr - rd_ptr);

`ifdef REG_IN_FIFO_BYPASS_EN
  assign bypass = datainv && fifo_empty && !pipe_stall;
`else
  assign bypass = 1'b0;
`endif

  // Fullness is judged on the current occupancy only; a same-cycle pop never admits a push.
  assign push = datainv && !fifo_full && !bypass;
  assign drop = datainv && fifo_full;
  assign pop  = !pipe_stall && !fifo_empty;

  // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    datavx1_nxt  = datavx1;
    datax1_nxt   = datax1;
    overflow_nxt = overflow || drop;

    if (push) wr_ptr_nxt = wr_ptr + PTR_W'(1);

    if (!pipe_stall) begin
      if (pop) begin
        datax1_nxt  = mem[rd_idx];
        datavx1_nxt = 1'b1;
        rd_ptr_nxt  = rd_ptr + PTR_W'(1);
      end else if (bypass) begin
        datax1_nxt  = datain;
        datavx1_nxt = 1'b1;
      end else begin
        datavx1_nxt = 1'b0;
      end
    end
  end

  // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values, whatever the statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      datavx1  <= 1'b0;
      datax1   <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      datavx1  <= datavx1_nxt;
      datax1   <= datax1_nxt;
      overflow <= overflow_nxt;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clock) begin
    if (push && !reset) mem[wr_idx] <= datain;
  end

endmodule

// File: tb/tb_reg_in_fifo.sv
// Table-driven bench for reg_in_fifo: one record per clock edge holding the inputs and the outputs expected after it.
// Expectations follow the default build; with REG_IN_FIFO_BYPASS_EN defined a bypass-specific table is used.
module tb_reg_in_fifo;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic              datainv;
  logic [DATA_W-1:0] datain;
  logic              inputs_full;
  logic              pipe_stall;
  logic              datavx1;
  logic [DATA_W-1:0] datax1;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic              rst;
    logic              inv;
    logic [DATA_W-1:0] din;
    logic              stall;
    logic              v;
    logic [DATA_W-1:0] d;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;
    logic              full;
  } vec_t;

  vec_t vecs[$];

  reg_in_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .datainv    (datainv),
    .datain     (datain),
    .inputs_full(inputs_full),
    .pipe_stall (pipe_stall),
    .datavx1    (datavx1),
    .datax1     (datax1),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic inv, input logic [DATA_W-1:0] din, input logic stall,
                     input logic v, input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] cnt,
                     input logic ovf, input logic full);
    vec_t r;
    r.rst = rst; r.inv = inv; r.din = din; r.stall = stall;
    r.v = v; r.d = d; r.cnt = cnt; r.ovf = ovf; r.full = full;
    vecs.push_back(r);
  endtask

  initial begin
    reset = 1'b1; datainv = 1'b0; datain = '0; pipe_stall = 1'b0;

    //   rst inv din       stall | v  d         cnt ovf full
    add(1, 1, 16'hAAAA, 0,   0, 16'h0000, 0, 0, 0);
    add(1, 1, 16'hAAAA, 0,   0, 16'h0000, 0, 0, 0);
`ifndef REG_IN_FIFO_BYPASS_EN
    // single word: two-edge latency, then the valid drops while the data holds
    add(0, 1, 16'h1234, 0,   0, 16'h0000, 1, 0, 0);
    add(0, 0, 16'h0000, 0,   1, 16'h1234, 0, 0, 0);
    add(0, 0, 16'h0000, 0,   0, 16'h1234, 0, 0, 0);
    // fill under stall, fifth word dropped
    add(0, 1, 16'h0001, 1,   0, 16'h1234, 1, 0, 0);
    add(0, 1, 16'h0002, 1,   0, 16'h1234, 2, 0, 0);
    add(0, 1, 16'h0003, 1,   0, 16'h1234, 3, 0, 0);
    add(0, 1, 16'h0004, 1,   0, 16'h1234, 4, 0, 1);
    add(0, 1, 16'h0005, 1,   0, 16'h1234, 4, 1, 1);
    // release: drain in order, overflow sticks
    add(0, 0, 16'h0000, 0,   1, 16'h0001, 3, 1, 0);
    add(0, 0, 16'h0000, 0,   1, 16'h0002, 2, 1, 0);
    add(0, 0, 16'h0000, 0,   1, 16'h0003, 1, 1, 0);
    add(0, 0, 16'h0000, 0,   1, 16'h0004, 0, 1, 0);
    add(0, 0, 16'h0000, 0,   0, 16'h0004, 0, 1, 0);
    add(1, 0, 16'h0000, 0,   0, 16'h0000, 0, 0, 0);
    // streaming 0x10..0x19: ten pushes wrap the 3-bit pointers
    add(0, 1, 16'h0010, 0,   0, 16'h0000, 1, 0, 0);
    for (int i = 1; i < 10; i++)
      add(0, 1, 16'(16'h10 + i), 0, 1, 16'(16'h10 + i - 1), 1, 0, 0);
    add(0, 0, 16'h0000, 0,   1, 16'h0019, 0, 0, 0);
    add(0, 0, 16'h0000, 0,   0, 16'h0019, 0, 0, 0);
    // stall hold on 0x20 while three more words arrive
    add(0, 1, 16'h0020, 0,   0, 16'h0019, 1, 0, 0);
    add(0, 1, 16'h0021, 0,   1, 16'h0020, 1, 0, 0);
    add(0, 1, 16'h0022, 1,   1, 16'h0020, 2, 0, 0);
    add(0, 1, 16'h0023, 1,   1, 16'h0020, 3, 0, 0);
    add(0, 1, 16'h0024, 1,   1, 16'h0020, 4, 0, 1);
    // full with a same-cycle pop: push still dropped
    add(0, 1, 16'h0025, 0,   1, 16'h0021, 3, 1, 0);
    // reset mid-operation discards stale words and the offered word
    add(1, 1, 16'hBEEF, 0,   0, 16'h0000, 0, 0, 0);
    add(0, 0, 16'h0000, 0,   0, 16'h0000, 0, 0, 0);
    add(0, 0, 16'h0000, 0,   0, 16'h0000, 0, 0, 0);
`else
    // bypass into empty FIFO: one-edge latency, no FIFO write
    add(0, 1, 16'h0055, 0,   1, 16'h0055, 0, 0, 0);
    // bypass while the held word is consumed
    add(0, 1, 16'h0066, 0,   1, 16'h0066, 0, 0, 0);
    // stalled: normal push
    add(0, 1, 16'h0077, 1,   1, 16'h0066, 1, 0, 0);
    // count>0: no bypass, ordinary push and pop
    add(0, 1, 16'h0088, 0,   1, 16'h0077, 1, 0, 0);
    add(0, 0, 16'h0000, 0,   1, 16'h0088, 0, 0, 0);
    add(0, 0, 16'h0000, 0,   0, 16'h0088, 0, 0, 0);
    add(1, 1, 16'hBEEF, 0,   0, 16'h0000, 0, 0, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      reset      = vecs[i].rst;
      datainv    = vecs[i].inv;
      datain     = vecs[i].din;
      pipe_stall = vecs[i].stall;
      @(posedge clock);
      #1;
      check("datavx1",     i, 32'(datavx1),     32'(vecs[i].v));
      check("datax1",      i, 32'(datax1),      32'(vecs[i].d));
      check("count",       i, 32'(count),       32'(vecs[i].cnt));
      check("overflow",    i, 32'(overflow),    32'(vecs[i].ovf));
      check("inputs_full", i, 32'(inputs_full), 32'(vecs[i].full));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_in_fifo.md
Name: reg_in_fifo

Overview:
- Input-side entry buffer of the microcontroller pipeline: the mirror of the output register path.
- Accepts words offered from outside the machine (datainv/datain) and buffers them in a small FIFO.
- Presents them to the first pipeline stage (x1) through a registered output that holds while the pipeline stalls.
- Raises inputs_full back to the outside so the source can throttle; drops and flags any word offered while full.

Parameters:
- DATA_W, 16: width of one data word (matches t_data).
- DEPTH, 4: FIFO entries, power of 2, minimum 2.
- CNT_W, $clog2(DEPTH)+1: width of the occupancy count, derived, not overridden.

Ports:
- clock  input  1  single clock, all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- datainv  input  1  outside source offers a word this cycle.
- datain  input  DATA_W  offered word.
- inputs_full  output  1  combinational, count==DEPTH; a word offered now is dropped.
- pipe_stall  input  1  pipeline x1 cannot accept; output register must hold.
- datavx1  output  1  registered; datax1 holds a valid word for stage x1.
- datax1  output  DATA_W  registered word for stage x1.
- count  output  CNT_W  registered FIFO occupancy 0..DEPTH, excludes the output register.
- overflow  output  1  registered sticky flag, set when a word is dropped.

Behaviour:
- Reset: on a posedge with reset=1, clear rd/wr pointers, count=0, datavx1=0, datax1=0 and overflow=0. Storage array contents are don't-care.
- Reset has priority over all other activity. A word offered in the reset cycle is discarded and does not set overflow.
- Pointers: (log2 DEPTH)+1 bits with a wrap bit.
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
  - count = wr_ptr - rd_ptr.
- Push: when datainv=1 and inputs_full=0, store datain at wr_ptr; wr_ptr++.
- Drop: when datainv=1 and inputs_full=1, discard the word and set overflow=1 (sticky until reset).
- inputs_full uses the current count only. A pop in the same cycle does not admit a push when full.
- Output register when pipe_stall=1: datavx1 and datax1 hold unchanged. No pop, even if datavx1=0.
- Output register when pipe_stall=0:
  - count>0: load datax1 <= mem[rd_ptr], datavx1 <= 1, rd_ptr++ (pop).
  - count==0: datavx1 <= 0; datax1 holds its last value.
- Latency, bypass compiled out: a word pushed at edge N into an empty FIFO, with pipe_stall=0, appears on datavx1/datax1 after edge N+1.
- Throughput: 1 word/cycle sustained under simultaneous push and pop, at any count between 0 and DEPTH-1.
- Simultaneous push and pop: the count is unchanged. At count==1, the popped word is the old head; the new word becomes head.
- Wrap-around: pointers wrap modulo 2*DEPTH; ordering is strictly FIFO across the wrap.
- The outside protocol needs no handshake beyond inputs_full. The source must not rely on a dropped word being retried.

Optional Feature:
- Macro: REG_IN_FIFO_BYPASS_EN.
- Defined: when count==0, pipe_stall=0 and datavx1 would otherwise be cleared, a word with datainv=1 loads straight into datax1 with datavx1<=1 at the same edge. No FIFO write; latency is 1 edge.
  - The bypass also applies when the output register currently holds a word that is being consumed (pipe_stall=0).
  - If count>0, the bypass never applies and normal push/pop occurs.
- Not defined: no bypass; latency is 2 edges as above.

Test Plan:
- Reset: assert reset 2 cycles with datainv=1, datain=16'hAAAA -> datavx1=0, datax1=0, count=0, overflow=0, inputs_full=0.
- Single word, bypass off: push 16'h1234 at edge N, pipe_stall=0 -> datavx1=1, datax1=16'h1234 after edge N+1; datavx1=0 after N+2.
- Fill and drop:
  - Stimulus: pipe_stall=1, push 5 words 1..5 (DEPTH=4), then release the stall.
  - Required response: count reaches 4, inputs_full=1, word 5 is dropped and overflow=1.
  - Release: datax1 sequence 1,2,3,4 on consecutive cycles, then datavx1=0; overflow stays 1.
- Streaming with wrap: push 10 consecutive words 16'h10..16'h19 with pipe_stall=0 -> output in the same order, no gaps after the first word, count ≤1, overflow=0.
- Stall hold: while datax1=16'h20 is valid, assert pipe_stall 3 cycles with pushes -> datax1 stays 16'h20 and count grows by 3. After release, the next word appears on the following edge.
- Reset mid-operation, and bypass:
  - With count=3 and datavx1=1, pulse reset one cycle -> all outputs return to their reset values; stale words are never presented.
  - With REG_IN_FIFO_BYPASS_EN defined: push 16'h55 at edge N into an empty FIFO -> datavx1=1, datax1=16'h55 after edge N, count stays 0.
